// File: rtl/bp_fe_icache_fetch_buffer.sv
// Fetch request tracker and response FIFO between the FE PC generator and bp_fe_icache.
// Define BP_FE_FETCH_BUF_STATS_EN to build the hit/drop statistics counters.
module bp_fe_icache_fetch_buffer #(
    parameter int vaddr_width_p = 39,
    parameter int instr_width_p = 32,
    parameter int els_p         = 16,
    parameter int inflight_p    = 2
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic [vaddr_width_p-1:0] fetch_vaddr_i,
    input  logic                     fetch_v_i,
    output logic                     fetch_ready_and_o,
    input  logic                     flush_i,
    output logic [vaddr_width_p-1:0] icache_vaddr_o,
    output logic                     icache_vaddr_v_o,
    input  logic                     icache_ready_i,
    input  logic [instr_width_p-1:0] icache_data_i,
    input  logic                     icache_data_v_i,
    input  logic                     icache_miss_v_i,
    output logic                     resp_v_o,
    output logic [vaddr_width_p-1:0] resp_vaddr_o,
    output logic [instr_width_p-1:0] resp_instr_o,
    output logic                     resp_miss_o,
    input  logic                     resp_yumi_i,
    output logic [31:0]              hit_cnt_o,
    output logic [31:0]              drop_cnt_o
);
    localparam int cnt_w_lp     = $clog2(els_p + 1);
    localparam int ptr_w_lp     = $clog2(els_p);
    localparam int out_w_lp     = $clog2(inflight_p + 1);
    localparam int ifl_ptr_w_lp = (inflight_p > 1) ? $clog2(inflight_p) : 1;

    typedef enum logic [1:0] {RUN, STALL, FLUSH} state_e;
    state_e state_q, state_d;

    logic [out_w_lp-1:0]      outstanding_q, outstanding_d;
    logic [ifl_ptr_w_lp-1:0]  pcq_wptr_q, pcq_wptr_d, pcq_rptr_q, pcq_rptr_d;
    logic [vaddr_width_p-1:0] pcq_mem_q [inflight_p];

    logic [cnt_w_lp-1:0]      count_q, count_d;
    logic [ptr_w_lp-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic [vaddr_width_p-1:0] fifo_pc_q    [els_p];
    logic [instr_width_p-1:0] fifo_instr_q [els_p];
    logic [els_p-1:0]         fifo_miss_q;

    logic [31:0] occupancy;
    logic        credit_ok, accept, resp_ev, resp_legal, enq, deq;

    // Every accepted request reserves a FIFO slot, so occupancy counts both.
    assign occupancy         = 32'(outstanding_q) + 32'(count_q);
    assign credit_ok         = (occupancy < 32'(els_p)) && (32'(outstanding_q) < 32'(inflight_p));
    assign fetch_ready_and_o = reset_n_i && (state_q == RUN) && !flush_i && icache_ready_i && credit_ok;
    assign accept            = fetch_v_i && fetch_ready_and_o;
    assign icache_vaddr_v_o  = accept;
    assign icache_vaddr_o    = accept ? fetch_vaddr_i : '0;

    assign resp_ev    = icache_data_v_i || icache_miss_v_i;
    assign resp_legal = resp_ev && (outstanding_q != '0);
    assign enq        = resp_legal && (state_q == RUN) && !flush_i;
    assign deq        = resp_yumi_i && resp_v_o && !flush_i;

    assign resp_v_o     = (count_q != '0);
    assign resp_vaddr_o = resp_v_o ? fifo_pc_q[rptr_q]    : '0;
    assign resp_instr_o = resp_v_o ? fifo_instr_q[rptr_q] : '0;
    assign resp_miss_o  = resp_v_o && fifo_miss_q[rptr_q];

    always_comb begin
        pcq_wptr_d    = pcq_wptr_q;
        pcq_rptr_d    = pcq_rptr_q;
        outstanding_d = outstanding_q;
        if (accept) begin
            pcq_wptr_d = (pcq_wptr_q == ifl_ptr_w_lp'(inflight_p - 1)) ? '0
                                                                       : pcq_wptr_q + ifl_ptr_w_lp'(1);
        end
        if (resp_legal) begin
            pcq_rptr_d = (pcq_rptr_q == ifl_ptr_w_lp'(inflight_p - 1)) ? '0
                                                                       : pcq_rptr_q + ifl_ptr_w_lp'(1);
        end
        case ({accept, resp_legal})
            2'b10:   outstanding_d = outstanding_q + out_w_lp'(1);
            2'b01:   outstanding_d = outstanding_q - out_w_lp'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (enq) wptr_d = wptr_q + ptr_w_lp'(1);
            if (deq) rptr_d = rptr_q + ptr_w_lp'(1);
            case ({enq, deq})
                2'b10:   count_d = count_q + cnt_w_lp'(1);
                2'b01:   count_d = count_q - cnt_w_lp'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Flush wins over a same-cycle miss; a flush with nothing in flight restarts at once.
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = (outstanding_q == '0) ? RUN : FLUSH;
        end else begin
            case (state_q)
                RUN:     if (enq && icache_miss_v_i) state_d = STALL;
                STALL:   state_d = STALL;
                FLUSH:   if (outstanding_q == '0) state_d = RUN;
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q       <= RUN;
            outstanding_q <= '0;
            pcq_wptr_q    <= '0;
            pcq_rptr_q    <= '0;
            count_q       <= '0;
            wptr_q        <= '0;
            rptr_q        <= '0;
        end else begin
            state_q       <= state_d;
            outstanding_q <= outstanding_d;
            pcq_wptr_q    <= pcq_wptr_d;
            pcq_rptr_q    <= pcq_rptr_d;
            count_q       <= count_d;
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) pcq_mem_q[pcq_wptr_q] <= fetch_vaddr_i;
        if (enq) begin
            fifo_pc_q[wptr_q]    <= pcq_mem_q[pcq_rptr_q];
            fifo_instr_q[wptr_q] <= icache_miss_v_i ? '0 : icache_data_i;
            fifo_miss_q[wptr_q]  <= icache_miss_v_i;
        end
    end

`ifdef BP_FE_FETCH_BUF_STATS_EN
    logic [31:0] hit_cnt_q, drop_cnt_q;
    logic        hit_ev, drop_ev;

    assign hit_ev  = enq && icache_data_v_i;
    assign drop_ev = resp_legal && !enq;

    // Statistics survive flushes and saturate rather than wrap.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            hit_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (hit_ev && (hit_cnt_q != '1))   hit_cnt_q  <= hit_cnt_q + 32'd1;
            if (drop_ev && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + 32'd1;
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign drop_cnt_o = drop_cnt_q;
`else
    assign hit_cnt_o  = '0;
    assign drop_cnt_o = '0;
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (reset_n_i && resp_ev)     assert (outstanding_q != '0);
        if (reset_n_i && resp_yumi_i) assert (resp_v_o);
    end
`endif

endmodule
